// File: rtl/display_pkg.sv
// display_pkg: shared scan-controller types and constants
//  estado_t    APAGADO (dark, parked), GUARDA (anodes off), MOSTRAR (one anode lit)
//  SEG_APAGADO all segments off (active-low)
//  ANODO_OFF   all anodes off (active-low), sliced to N_DIGITOS by users
package display_pkg;
  typedef enum logic [1:0] {APAGADO, GUARDA, MOSTRAR} estado_t;
  localparam logic [6:0] SEG_APAGADO = 7'h7F;
  localparam logic [7:0] ANODO_OFF = 8'hFF;
endpackage

// File: rtl/controlador_display_if.sv
// controlador_display_if: bus between set/timekeeping logic and the display scanner
//  master: drives habilitar, digitos, parpadeo_mask, punto_mask; reads the pin outputs
//  slave:  the scanner; drives anodo, segmento, dp, inicio_trama
interface controlador_display_if #(parameter int N_DIGITOS = 6);
  logic habilitar;
  logic [4*N_DIGITOS-1:0] digitos;
  logic [N_DIGITOS-1:0] parpadeo_mask;
  logic [N_DIGITOS-1:0] punto_mask;
  logic [N_DIGITOS-1:0] anodo;
  logic [6:0] segmento;
  logic dp;
  logic inicio_trama;
  modport master(output habilitar, digitos, parpadeo_mask, punto_mask,
                 input anodo, segmento, dp, inicio_trama);
  modport slave(input habilitar, digitos, parpadeo_mask, punto_mask,
                output anodo, segmento, dp, inicio_trama);
endinterface

// File: rtl/display7segmentos.sv
// display7segmentos: BCD to common-anode 7-segment decoder, {G..A} active-low
//  digito   in  4  BCD value; 10..15 blank the digit
//  segmento out 7  segment drive
module display7segmentos
  import display_pkg::*;
(
  input  logic [3:0] digito,
  output logic [6:0] segmento
);
  always_comb begin
    case (digito)
      4'd0: segmento = 7'h40;
      4'd1: segmento = 7'h79;
      4'd2: segmento = 7'h24;
      4'd3: segmento = 7'h30;
      4'd4: segmento = 7'h19;
      4'd5: segmento = 7'h12;
      4'd6: segmento = 7'h02;
      4'd7: segmento = 7'h78;
      4'd8: segmento = 7'h00;
      4'd9: segmento = 7'h10;
      default: segmento = SEG_APAGADO;
    endcase
  end
endmodule

// File: rtl/controlador_display.sv
// controlador_display: time-multiplexed scanner for a common-anode 7-segment bank
//  clk, rst_n  clock and asynchronous active-low reset
//  bus (slave) habilitar/digitos/parpadeo_mask/punto_mask in; anodo/segmento/dp/inicio_trama out
module controlador_display
  import display_pkg::*;
#(
  parameter int N_DIGITOS = 6,
  parameter int CICLOS_POR_DIGITO = 50000,
  parameter int GUARDA_CICLOS = 500,
  parameter int CICLOS_PARPADEO = 12500000
) (
  input logic clk,
  input logic rst_n,
  controlador_display_if.slave bus
);
  localparam int CW = $clog2(CICLOS_POR_DIGITO);
  localparam int IW = N_DIGITOS > 1 ? $clog2(N_DIGITOS) : 1;
  localparam int BW = $clog2(CICLOS_PARPADEO);
  if (N_DIGITOS < 1 || N_DIGITOS > 8 || GUARDA_CICLOS < 1 || GUARDA_CICLOS >= CICLOS_POR_DIGITO) begin : g_param_err
    $error("controlador_display: illegal parameters");
  end
  estado_t est, est_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [BW-1:0] bl;
  logic fase, fase_n;
  logic [4*N_DIGITOS-1:0] snap, snap_n;
  logic [N_DIGITOS-1:0] psnap, psnap_n;
  logic [3:0] sel;
  logic entra_guarda, trama_n;
  always_comb begin
    est_n = est;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    if (!bus.habilitar) begin
      est_n = APAGADO;
      cnt_n = '0;
      idx_n = '0;
    end else begin
      case (est)
        APAGADO: begin
          est_n = GUARDA;
          cnt_n = '0;
          idx_n = '0;
        end
        GUARDA: est_n = cnt == CW'(GUARDA_CICLOS - 1) ? MOSTRAR : GUARDA;
        default: if (cnt == CW'(CICLOS_POR_DIGITO - 1)) begin
          est_n = GUARDA;
          cnt_n = '0;
          idx_n = idx == IW'(N_DIGITOS - 1) ? '0 : idx + 1'b1;
        end
      endcase
    end
    entra_guarda = est_n == GUARDA && est != GUARDA;
    trama_n = entra_guarda && idx_n == '0;
    // inputs are frozen at frame start so a frame never mixes old and new digits
    snap_n = trama_n ? bus.digitos : snap;
    psnap_n = trama_n ? bus.punto_mask : psnap;
    fase_n = bl == BW'(CICLOS_PARPADEO - 1) ? ~fase : fase;
  end
  // outputs are registered from next-state values so the pins line up with the FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est <= APAGADO;
      cnt <= '0;
      idx <= '0;
      bl <= '0;
      fase <= 1'b0;
      snap <= '0;
      psnap <= '0;
      sel <= '0;
      bus.anodo <= ANODO_OFF[N_DIGITOS-1:0];
      bus.dp <= 1'b1;
      bus.inicio_trama <= 1'b0;
    end else begin
      est <= est_n;
      cnt <= cnt_n;
      idx <= idx_n;
      bl <= bl == BW'(CICLOS_PARPADEO - 1) ? '0 : bl + 1'b1;
      fase <= fase_n;
      snap <= snap_n;
      psnap <= psnap_n;
      sel <= entra_guarda ? snap_n[idx_n*4 +: 4] : sel;
      bus.anodo <= est_n == MOSTRAR && !(fase_n && bus.parpadeo_mask[idx_n])
                   ? ~(N_DIGITOS'(1) << idx_n) : ANODO_OFF[N_DIGITOS-1:0];
      bus.dp <= ~(est_n == MOSTRAR && psnap_n[idx_n]);
      bus.inicio_trama <= trama_n;
    end
  end
  display7segmentos u_dec (.digito(sel), .segmento(bus.segmento));
endmodule

// File: tb/tb_controlador_display.sv
// tb_controlador_display: randomized scoreboard bench against a slot/frame timing model
module tb_controlador_display;
  localparam int N = 4, C = 8, G = 2, P = 64;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    logic tr;
  } obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  controlador_display_if #(.N_DIGITOS(N)) bus ();
  controlador_display #(
    .N_DIGITOS(N), .CICLOS_POR_DIGITO(C), .GUARDA_CICLOS(G), .CICLOS_PARPADEO(P)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  obs_t q[$];
  int checks = 0, errors = 0;
  logic [6:0] tabla [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  bit run;
  int t, k;
  logic [15:0] snap, d;
  logic [3:0] snapp, sel, dm;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic reset_model();
    run = 0; t = 0; k = 0; snap = '0; snapp = '0; sel = '0;
  endtask
  // Expected pins after the coming edge: t counts cycles since frame start,
  // slot = t/C, lit once the first G cycles of the slot have passed.
  task automatic drive_push(input bit h, input logic [15:0] dg, input logic [3:0] pm, input logic [3:0] pt);
    obs_t e;
    int slot, pos;
    bit lit, fase;
    bus.habilitar = h; bus.digitos = dg; bus.parpadeo_mask = pm; bus.punto_mask = pt;
    k++;
    if (!h) run = 0;
    else if (!run) begin run = 1; t = 0; end
    else t = (t + 1) % (N * C);
    e.tr = run && t == 0;
    if (e.tr) begin snap = dg; snapp = pt; end
    slot = t / C;
    pos = t % C;
    lit = run && pos >= G;
    fase = ((k / P) % 2) == 1;
    if (run && pos == 0) sel = snap[slot*4 +: 4];
    e.an = (lit && !(fase && pm[slot])) ? ~(4'b1 << slot) : 4'hF;
    e.seg = tabla[sel];
    e.dp = !(lit && snapp[slot]);
    q.push_back(e);
  endtask
  task automatic step(input bit h, input logic [15:0] dg, input logic [3:0] pm, input logic [3:0] pt);
    @(negedge clk);
    drive_push(h, dg, pm, pt);
  endtask
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("anodo", 32'(bus.anodo), 32'(e.an));
        chk("segmento", 32'(bus.segmento), 32'(e.seg));
        chk("dp", 32'(bus.dp), 32'(e.dp));
        chk("inicio_trama", 32'(bus.inicio_trama), 32'(e.tr));
      end
    end
  end
  initial begin
    bus.habilitar = 0; bus.digitos = '0; bus.parpadeo_mask = '0; bus.punto_mask = '0;
    reset_model();
    #12;
    chk("reset_anodo", 32'(bus.anodo), 32'hF);
    chk("reset_segmento", 32'(bus.segmento), 32'h40);
    chk("reset_dp", 32'(bus.dp), 32'h1);
    chk("reset_trama", 32'(bus.inicio_trama), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    drive_push(0, '0, '0, '0);
    for (int i = 0; i < 80; i++) step(1, 16'h4321, 4'b0000, 4'b0000);
    d = 16'h4321; dm = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) d = 16'($urandom);
      if ($urandom_range(0, 31) == 0) dm = 4'($urandom);
      step(1, d, 4'b0000, dm);
    end
    for (int i = 0; i < 200; i++) step(1, d, 4'b0010, dm);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) d = 16'($urandom);
      step($urandom_range(0, 29) != 0, d, 4'($urandom), 4'($urandom));
    end
    for (int i = 0; i < 40 && !(run && (t % C) >= G); i++) step(1, d, 4'b0000, 4'b1111);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_anodo", 32'(bus.anodo), 32'hF);
    chk("async_dp", 32'(bus.dp), 32'h1);
    chk("async_segmento", 32'(bus.segmento), 32'h40);
    chk("async_trama", 32'(bus.inicio_trama), 32'h0);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    drive_push(1, d, 4'b0000, dm);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) d = 16'($urandom);
      step($urandom_range(0, 39) != 0, d, 4'($urandom), 4'($urandom));
    end
    @(negedge clk);
    @(negedge clk);
    chk("cola_vacia", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
